// File: rtl/value_uart_reporter_if.sv
// Value bus into the reporter and the UART/busy status coming back out.
// The reporter uses the slave view; whoever drives the value uses the master view.
interface value_uart_reporter_if;
    logic [7:0] i_value;
    logic       o_tx;
    logic       o_busy;

    modport master (output i_value, input o_tx, input o_busy);
    modport slave  (input i_value, output o_tx, output o_busy);
endinterface

// File: rtl/value_uart_reporter.sv
// Reports every change of an 8-bit value as a "DDD\r\n" line on an 8N1 UART TX pin.
// Changes that arrive while a line is being sent collapse to the newest value.
module value_uart_reporter #(
    parameter int INPUT_CLOCK_HZ = 27000000,
    parameter int BAUD_RATE      = 115200
) (
    input logic                  i_clk,
    input logic                  i_rst,
    value_uart_reporter_if.slave bus
);
    localparam int CLKS_PER_BIT = INPUT_CLOCK_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, CONVERT, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [7:0]      sample_q;
    logic [7:0]      sent_q;
    logic [11:0]     digits_q;
    logic [11:0]     digits_d;
    logic [CW-1:0]   baudCnt_q;
    logic [2:0]      bitIdx_q;
    logic [2:0]      byteIdx_q;
    logic            tx_q;
    logic            busy_q;
    logic [7:0]      curByte;

    // Unrolled double dabble, so the whole conversion fits in one CONVERT cycle.
    function automatic logic [11:0] toBcd(input logic [7:0] bin);
        logic [19:0] s;
        s = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = {s[18:0], 1'b0};
        end
        return s[19:8];
    endfunction

    always_comb begin
        digits_d = toBcd(sent_q);
    end

    always_comb begin
        curByte = 8'h0A;
        case (byteIdx_q)
            3'd0:    curByte = {4'h3, digits_q[11:8]};
            3'd1:    curByte = {4'h3, digits_q[7:4]};
            3'd2:    curByte = {4'h3, digits_q[3:0]};
            3'd3:    curByte = 8'h0D;
            default: curByte = 8'h0A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            sample_q  <= 8'd0;
            sent_q    <= 8'd0;
            digits_q  <= 12'd0;
            baudCnt_q <= '0;
            bitIdx_q  <= 3'd0;
            byteIdx_q <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            sample_q <= bus.i_value;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (sample_q != sent_q) begin
                        sent_q  <= sample_q;
                        busy_q  <= 1'b1;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    digits_q  <= digits_d;
                    byteIdx_q <= 3'd0;
                    baudCnt_q <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= START;
                end
                START: begin
                    if (baudCnt_q == LAST_TICK) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= 3'd0;
                        tx_q      <= curByte[0];
                        state_q   <= DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baudCnt_q == LAST_TICK) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            tx_q     <= curByte[bitIdx_q + 3'd1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                STOP: begin
                    // The next start bit follows the stop bit directly, with no idle gap.
                    if (baudCnt_q == LAST_TICK) begin
                        baudCnt_q <= '0;
                        if (byteIdx_q == 3'd4) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            byteIdx_q <= byteIdx_q + 3'd1;
                            tx_q      <= 1'b0;
                            state_q   <= START;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_tx   = tx_q;
    assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_value_uart_reporter.sv
// Drives values into value_uart_reporter, decodes its UART line and compares the
// decoded text with "%03d\r\n" of the value that the coalescing rule says is due.
module tb_value_uart_reporter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    int   changeCycle = 0;
    int   lastBusyFall = 0;
    int   firstLat = -1;
    logic [7:0] modelSent = 8'd0;
    logic prevTx = 1'b1;
    logic prevBusy = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         startCycle;
        bit         shapeOk;
    } rx_t;
    rx_t rxQ[$];

    value_uart_reporter_if vif();

    value_uart_reporter #(
        .INPUT_CLOCK_HZ(1000000),
        .BAUD_RATE(100000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Each bit is sampled on all 10 of its cycles so a short or glitchy bit is caught.
    initial begin : uartMonitor
        int startCyc;
        bit ok;
        bit aborted;
        logic [7:0] data;
        logic first;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prevTx = 1'b1;
            end else if (prevTx === 1'b1 && vif.o_tx === 1'b0) begin
                startCyc = cycle;
                ok = 1'b1;
                aborted = 1'b0;
                data = '0;
                first = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < 10 && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst !== 1'b0) aborted = 1'b1;
                        else if (c == 0) first = vif.o_tx;
                        else if (vif.o_tx !== first) ok = 1'b0;
                    end
                    if (b == 0 && first !== 1'b0) ok = 1'b0;
                    if (b >= 1 && b <= 8) data[b-1] = first;
                    if (b == 9 && first !== 1'b1) ok = 1'b0;
                end
                if (!aborted) rxQ.push_back(rx_t'{data, startCyc, ok});
                prevTx = aborted ? 1'b1 : vif.o_tx;
            end else begin
                prevTx = vif.o_tx;
            end
        end
    end

    always @(negedge clk) begin
        if (prevBusy === 1'b1 && vif.o_busy === 1'b0) lastBusyFall = cycle;
        prevBusy = vif.o_busy;
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v);
        @(negedge clk);
        vif.i_value = v;
        changeCycle = cycle;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitTxFall(input string tag, output int fallCyc);
        int n = 0;
        while (vif.o_tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_txfall"}, vif.o_tx, 1'b0);
        fallCyc = cycle;
    endtask

    task automatic waitBusyFall(input string tag, output int fallCyc);
        int n = 0;
        while (vif.o_busy !== 1'b0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busyfall"}, vif.o_busy, 1'b0);
        fallCyc = cycle;
    endtask

    task automatic checkFrame(input logic [7:0] v, input string tag, input int busyFall);
        string s;
        rx_t r;
        int firstStart;
        int prevStart;
        s = $sformatf("%03d\r\n", v);
        checkOutput({tag, "_nbytes"}, rxQ.size() >= 5, 1);
        if (rxQ.size() < 5) return;
        firstStart = rxQ[0].startCycle;
        prevStart = firstStart;
        for (int i = 0; i < 5; i++) begin
            r = rxQ.pop_front();
            checkOutput($sformatf("%s_byte%0d", tag, i), r.data, s[i]);
            checkOutput($sformatf("%s_shape%0d", tag, i), r.shapeOk, 1);
            if (i > 0) checkOutput($sformatf("%s_spacing%0d", tag, i), r.startCycle - prevStart, 100);
            prevStart = r.startCycle;
        end
        checkOutput({tag, "_len"}, busyFall - firstStart, 500);
    endtask

    task automatic runFrame(input logic [7:0] v, input string tag);
        int st;
        int bf;
        int lat;
        applyStimulus(v);
        waitTxFall(tag, st);
        lat = st - changeCycle;
        checkOutput({tag, "_lat"}, lat >= 1 && lat <= 13, 1);
        if (firstLat >= 0) checkOutput({tag, "_latconst"}, lat, firstLat);
        else firstLat = lat;
        waitBusyFall(tag, bf);
        waitCycles(2);
        checkFrame(v, tag, bf);
        modelSent = v;
    endtask

    initial begin : main
        int st;
        int bf1;
        int bf2;
        int bad;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [7:0] v3;
        int t1;
        int t2;
        bit second;

        vif.i_value = 8'd0;
        rst = 1'b1;
        waitCycles(3);
        checkOutput("rst_tx", vif.o_tx, 1'b1);
        checkOutput("rst_busy", vif.o_busy, 1'b0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vif.o_tx !== 1'b1 || vif.o_busy !== 1'b0) bad++;
        end
        checkOutput("idle_after_reset", bad, 0);
        checkOutput("idle_no_frame", rxQ.size(), 0);

        runFrame(8'd42, "v42");
        runFrame(8'd255, "v255");
        runFrame(8'd0, "wrap0");
        runFrame(8'd100, "v100");

        // Coalescing: 8 is overwritten by 9 before the 7-frame ends.
        applyStimulus(8'd7);
        waitTxFall("coal", st);
        waitCycles(100);
        vif.i_value = 8'd8;
        waitCycles(100);
        vif.i_value = 8'd9;
        waitBusyFall("coal1", bf1);
        waitTxFall("coal2", st);
        checkOutput("coal_gap", st - bf1 <= 2, 1);
        waitBusyFall("coal2", bf2);
        waitCycles(2);
        checkFrame(8'd7, "coal_first", bf1);
        checkFrame(8'd9, "coal_second", bf2);
        waitCycles(100);
        checkOutput("coal_extra", rxQ.size(), 0);
        checkOutput("coal_idle_busy", vif.o_busy, 1'b0);
        modelSent = 8'd9;

        applyStimulus(8'd5);
        waitTxFall("revert", st);
        waitCycles(100);
        vif.i_value = 8'd6;
        waitCycles(200);
        vif.i_value = 8'd5;
        waitBusyFall("revert", bf1);
        waitCycles(2);
        checkFrame(8'd5, "revert", bf1);
        waitCycles(100);
        checkOutput("revert_extra", rxQ.size(), 0);
        checkOutput("revert_idle_busy", vif.o_busy, 1'b0);
        modelSent = 8'd5;

        for (int i = 0; i < 6; i++) begin
            v1 = 8'($urandom_range(0, 255));
            while (v1 == modelSent) v1 = 8'($urandom_range(0, 255));
            runFrame(v1, $sformatf("rand%0d", i));
        end

        // Random coalescing: the newest value at frame end is due, unless it equals the one just sent.
        for (int i = 0; i < 3; i++) begin
            v1 = 8'($urandom_range(0, 255));
            while (v1 == modelSent) v1 = 8'($urandom_range(0, 255));
            v2 = 8'($urandom_range(0, 255));
            while (v2 == v1) v2 = 8'($urandom_range(0, 255));
            v3 = ($urandom_range(0, 2) == 0) ? v1 : 8'($urandom_range(0, 255));
            t1 = $urandom_range(20, 200);
            t2 = $urandom_range(20, 200);
            second = (v3 != v1);
            applyStimulus(v1);
            waitTxFall($sformatf("rcoal%0d", i), st);
            waitCycles(t1);
            vif.i_value = v2;
            waitCycles(t2);
            vif.i_value = v3;
            waitBusyFall($sformatf("rcoal%0d", i), bf1);
            waitCycles(600);
            checkOutput($sformatf("rcoal%0d_count", i), rxQ.size(), second ? 10 : 5);
            if (second && rxQ.size() >= 6)
                checkOutput($sformatf("rcoal%0d_gap", i), rxQ[5].startCycle - bf1 <= 2, 1);
            checkFrame(v1, $sformatf("rcoal%0d_a", i), bf1);
            if (second) checkFrame(v3, $sformatf("rcoal%0d_b", i), lastBusyFall);
            rxQ.delete();
            modelSent = v3;
        end

        runFrame(8'd77, "pre_reset");

        // Reset lands inside the data bits of the third byte.
        applyStimulus(8'd5);
        waitTxFall("midrst", st);
        waitCycles(250);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx", vif.o_tx, 1'b1);
        checkOutput("midrst_busy", vif.o_busy, 1'b0);
        waitCycles(2);
        rst = 1'b0;
        rxQ.delete();
        waitTxFall("midrst_again", st);
        waitBusyFall("midrst_again", bf1);
        waitCycles(2);
        checkFrame(8'd5, "midrst_again", bf1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
